axi4lite_slave_regs: RTL and testbench
======================================

# axi4lite_slave_regs

AXI4-Lite responder (slave) end of the team's AXI4-Lite link: accepts write and read transactions from an AXI4-Lite master over the five standard channels and maps them onto a small bank of 32-bit read/write registers. It sits on the far side of the interconnect from the master wrapper. It exposes the register contents and per-register write strobes to the surrounding user logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; word index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4, number of implemented registers, 1..2^(ADDR_WIDTH-2).
- aclk  in  1  single clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- awaddr  in  ADDR_WIDTH  write address; awprot in 3, accepted and ignored.
- awvalid in 1 / awready out 1  write-address handshake.
- wdata  in  DATA_WIDTH  write data, full-word writes only (no strobes).
- wvalid in 1 / wready out 1  write-data handshake.
- bresp  out  2  write response; bvalid out 1 / bready in 1.
- araddr  in  ADDR_WIDTH  read address; arprot in 3, accepted and ignored.
- arvalid in 1 / arready out 1  read-address handshake.
- rdata out DATA_WIDTH, rresp out 2, rvalid out 1 / rready in 1  read data channel.
- regs_q  out  NUM_REGS*DATA_WIDTH  register contents, reg k at bits [k*32+:32].
- wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle register k is updated.

## Operation
- Reset: all registers 0; awready, wready, arready, bvalid, rvalid, wr_pulse = 0; bresp, rresp, rdata = 0.
- AW and W channels are independent: each has a one-entry hold (address / data). awready = 1 iff AW hold empty and no B pending; same for wready with W hold.
- AW and W may arrive in either order or together; a channel whose hold is full stalls its ready low.
- Commit when both holds full and bvalid = 0: word index < NUM_REGS → register written, wr_pulse[idx] = 1, bresp = OKAY (2'b00); else no write, no pulse, bresp = SLVERR (2'b10). Both holds cleared, bvalid = 1.
- bvalid and bresp held stable until bready; then bvalid = 0.
- Read: arready = 1 iff rvalid = 0. On AR handshake: rdata = reg[idx], rresp = OKAY, or rdata = 0, rresp = SLVERR if idx ≥ NUM_REGS; rvalid = 1. rdata/rresp stable until rready.
- Read and write paths fully concurrent; no arbitration.
- Read and commit to the same register on the same edge: read returns the pre-write value.
- Reset asserted mid-transaction: all holds and pending responses discarded, outputs to reset values immediately (asynchronous).

## Timing
- Ready signals are registered; all go 1 on the first edge after areset deasserts.
- Write: AW+W handshake edge N → commit, wr_pulse, bvalid = 1 after edge N+1 → B handshake earliest edge N+2 → awready/wready = 1 after N+2. Max throughput 1 write / 3 cycles.
- Staggered AW then W: commit one edge after the later handshake.
- Read: AR handshake edge N → rvalid = 1 after edge N → R handshake earliest edge N+1 → arready = 1 after it. Max 1 read / 2 cycles.
- regs_q updates on the commit edge; wr_pulse high for exactly that one cycle.
- valid outputs never depend combinationally on ready inputs.

## Structure
- Shared package/include axi_lite_defs: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, word-index helper width constant; the master side uses the same definitions.
- One sub-module: axi4lite_regbank (register array, write port with pulse, read mux with range check); the top holds channel holds and handshake logic.

## Test plan
- Reset then write 0xDEADBEEF to 0x4 (AW and W same cycle, bready = 1) → bvalid after 2 cycles, bresp = 00, wr_pulse[1] one cycle, regs_q[63:32] = 0xDEADBEEF; read 0x4 → rdata 0xDEADBEEF, rresp 00.
- W 3 cycles before AW to 0x8, value 0x12345678 → wready low after W handshake, commit one edge after AW handshake, reg 2 = 0x12345678.
- bready held low 5 cycles → bvalid/bresp stable, awready and wready stay 0; second write accepted only after B handshake.
- NUM_REGS = 3, write 0xC then read 0xC → bresp = 10, no wr_pulse, regs unchanged; rresp = 10, rdata = 0.
- rready low 4 cycles during read of reg 0 → rdata stable, arready 0; simultaneous write to reg 0 in the AR handshake cycle → read returns old value.
- areset pulsed with bvalid and rvalid pending → all ready/valid 0 at once, registers 0, readies 1 one edge after release.

Source files
------------

// File: rtl/axi4lite_slave_regs_pkg.sv
// Shared AXI4-Lite definitions for the register-bank responder and its master-side peer.
package axi4lite_slave_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte address bits below this are dropped to form the word index.
    localparam int WORD_LSB = 2;

    function automatic int idx_width(input int addr_width);
        return addr_width - WORD_LSB;
    endfunction

endpackage

// File: rtl/axi4lite_slave_regs_if.sv
// Five-channel AXI4-Lite bus bundle. Every channel uses valid/ready: a transfer
// happens on a rising edge where both are high; valid and payload hold until then.
interface axi4lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_regbank.sv
// Register array with a single write port (one-cycle update pulse) and a
// range-checked combinational read mux.
module axi4lite_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 2,
    parameter int NUM_REGS   = 4
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           we,
    input  logic [IDX_WIDTH-1:0]           widx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic                           wr_ok,
    input  logic [IDX_WIDTH-1:0]           ridx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_ok,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    assign wr_ok = 32'(widx) < NUM_REGS;
    assign rd_ok = 32'(ridx) < NUM_REGS;

    // Out-of-range indices fall through the loop and read as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (32'(ridx) == k) rd_data = regs_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            regs_q   <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (we && 32'(widx) == k) begin
                    regs_q[k*DATA_WIDTH +: DATA_WIDTH] <= wdata;
                    wr_pulse[k]                        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder: one-entry AW and W holds, commit into the register bank,
// and an independent single-outstanding read path.
module axi4lite_slave_regs
    import axi4lite_slave_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    axi4lite_slave_regs_if.slave                   s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_q,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int IW = idx_width(C_S_AXI_ADDR_WIDTH);

    logic          awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;
    logic          aw_full, w_full;
    logic [IW-1:0] aw_idx;
    logic [DW-1:0] w_data;
    logic          aw_hs, w_hs, ar_hs, commit;
    logic          aw_full_n, w_full_n, bvalid_n, rvalid_n;
    logic          wr_ok, rd_ok;
    logic [DW-1:0] rd_data;
    logic          unused_bits;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.arready = arready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[WORD_LSB-1:0], s_axi.araddr[WORD_LSB-1:0]};

    assign aw_hs  = s_axi.awvalid && awready_q;
    assign w_hs   = s_axi.wvalid  && wready_q;
    assign ar_hs  = s_axi.arvalid && arready_q;
    assign commit = aw_full && w_full && !bvalid_q;

    // A handshake can only land on an empty hold, so it never collides with commit.
    always_comb begin
        aw_full_n = commit ? 1'b0 : (aw_full || aw_hs);
        w_full_n  = commit ? 1'b0 : (w_full  || w_hs);
        bvalid_n  = commit ? 1'b1 : (bvalid_q && !s_axi.bready);
        rvalid_n  = ar_hs  ? 1'b1 : (rvalid_q && !s_axi.rready);
    end

    axi4lite_regbank #(
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW),
        .NUM_REGS   (NUM_REGS)
    ) u_regbank (
        .aclk     (aclk),
        .areset   (areset),
        .we       (commit),
        .widx     (aw_idx),
        .wdata    (w_data),
        .wr_ok    (wr_ok),
        .ridx     (s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:WORD_LSB]),
        .rd_data  (rd_data),
        .rd_ok    (rd_ok),
        .regs_q   (regs_q),
        .wr_pulse (wr_pulse)
    );

    // Readies are computed from next-state so they are registered yet never stale.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_idx    <= '0;
            w_data    <= '0;
        end else begin
            aw_full   <= aw_full_n;
            w_full    <= w_full_n;
            bvalid_q  <= bvalid_n;
            rvalid_q  <= rvalid_n;
            awready_q <= !aw_full_n && !bvalid_n;
            wready_q  <= !w_full_n  && !bvalid_n;
            arready_q <= !rvalid_n;
            if (aw_hs) aw_idx <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:WORD_LSB];
            if (w_hs)  w_data <= s_axi.wdata;
            if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (ar_hs) begin
                rdata_q <= rd_ok ? rd_data : '0;
                rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Randomized bench for axi4lite_slave_regs (3 registers, so address 0xC is out of range)
// checked against a plain array model of the register file.
module tb_axi4lite_slave_regs;

    localparam int NREG = 3;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic [NREG*32-1:0] regs_q;
    logic [NREG-1:0]    wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [4];
    logic [33:0] exp_q [$];

    axi4lite_slave_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    axi4lite_slave_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .NUM_REGS           (NREG)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_axi    (bus),
        .regs_q   (regs_q),
        .wr_pulse (wr_pulse)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREG*32-1:0] model_flat();
        logic [NREG*32-1:0] f;
        for (int k = 0; k < NREG; k++) f[k*32 +: 32] = model_mem[k];
        return f;
    endfunction

    function automatic logic [33:0] model_read(input logic [3:0] addr);
        int idx;
        idx = int'(addr) / 4;
        if (idx < NREG) return {2'b00, model_mem[idx]};
        return {2'b10, 32'h0};
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, b_done = 0, awhs, whs, bhs;
        int cyc = 0, aw_cyc = -1, w_cyc = -1, first = -1, idx;
        logic [1:0]      exp_resp;
        logic [NREG-1:0] exp_pulse;
        idx       = int'(addr) / 4;
        exp_resp  = (idx < NREG) ? 2'b00 : 2'b10;
        exp_pulse = (idx < NREG) ? NREG'(1 << idx) : '0;
        while (!b_done && cyc < 60) begin
            bus.awaddr  = addr;
            bus.wdata   = data;
            bus.awvalid = !aw_done && cyc >= aw_dly;
            bus.wvalid  = !w_done && cyc >= w_dly;
            bus.bready  = aw_done && w_done && cyc >= ((aw_cyc > w_cyc) ? aw_cyc : w_cyc) + 2 + b_dly;
            @(negedge aclk);
            bhs = 0;
            if (bus.bvalid) begin
                if (first < 0) begin
                    first = cyc;
                    check_eq("b_latency", cyc,
                             (aw_done && w_done) ? ((aw_cyc > w_cyc) ? aw_cyc : w_cyc) + 2 : -1);
                    if (idx < NREG) model_mem[idx] = data;
                    check_eq("wr_pulse", wr_pulse, exp_pulse);
                    check_eq("regs_q", regs_q, model_flat());
                end else begin
                    check_eq("wr_pulse_once", wr_pulse, 0);
                end
                check_eq("bresp", bus.bresp, exp_resp);
                check_eq("awready_b_pend", bus.awready, 0);
                check_eq("wready_b_pend", bus.wready, 0);
                bhs = bus.bready;
            end else begin
                check_eq("wr_pulse_idle", wr_pulse, 0);
            end
            if (w_done && !aw_done) check_eq("wready_held", bus.wready, 0);
            if (aw_done && !w_done) check_eq("awready_held", bus.awready, 0);
            awhs = bus.awvalid && bus.awready;
            whs  = bus.wvalid && bus.wready;
            @(posedge aclk);
            #1;
            if (awhs) begin aw_done = 1; aw_cyc = cyc; end
            if (whs)  begin w_done = 1;  w_cyc = cyc;  end
            if (bhs)  b_done = 1;
            cyc++;
        end
        bus.awvalid = 0;
        bus.wvalid  = 0;
        bus.bready  = 0;
        if (!b_done) check_eq("wr_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [3:0] addr, input int ar_dly, input int r_dly);
        bit ar_done = 0, r_done = 0, arhs, rhs;
        int cyc = 0, hs_cyc = -1, first = -1;
        while (!r_done && cyc < 60) begin
            bus.araddr  = addr;
            bus.arvalid = !ar_done && cyc >= ar_dly;
            bus.rready  = ar_done && cyc >= hs_cyc + 1 + r_dly;
            @(negedge aclk);
            rhs = 0;
            if (bus.rvalid) begin
                if (exp_q.size() == 0) begin
                    check_eq("rvalid_spurious", 1, 0);
                end else begin
                    if (first < 0) begin
                        first = cyc;
                        check_eq("r_latency", cyc, hs_cyc + 1);
                    end
                    check_eq("rdata", bus.rdata, exp_q[0][31:0]);
                    check_eq("rresp", bus.rresp, exp_q[0][33:32]);
                    check_eq("arready_r_pend", bus.arready, 0);
                    rhs = bus.rready;
                end
            end
            arhs = bus.arvalid && bus.arready;
            if (arhs) exp_q.push_back(model_read(addr));
            @(posedge aclk);
            #1;
            if (arhs) begin ar_done = 1; hs_cyc = cyc; end
            if (rhs) begin r_done = 1; void'(exp_q.pop_front()); end
            cyc++;
        end
        bus.arvalid = 0;
        bus.rready  = 0;
        if (!r_done) check_eq("rd_timeout", 0, 1);
    endtask

    task automatic check_all_idle_zero(input string tag);
        check_eq({tag, "_awready"}, bus.awready, 0);
        check_eq({tag, "_wready"}, bus.wready, 0);
        check_eq({tag, "_arready"}, bus.arready, 0);
        check_eq({tag, "_bvalid"}, bus.bvalid, 0);
        check_eq({tag, "_rvalid"}, bus.rvalid, 0);
        check_eq({tag, "_resp"}, {bus.bresp, bus.rresp}, 0);
        check_eq({tag, "_rdata"}, bus.rdata, 0);
        check_eq({tag, "_regs"}, regs_q, 0);
        check_eq({tag, "_pulse"}, wr_pulse, 0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) model_mem[k] = '0;
        bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 0;
        bus.wdata = '0;  bus.wvalid = 0;      bus.bready = 0;
        bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 0; bus.rready = 0;

        // Reset state, then readies rise on the first edge after release.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_all_idle_zero("rst");
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check_eq("ready_pre_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge aclk);
        check_eq("ready_post_edge", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(posedge aclk); #1;

        // Aligned AW+W, then read back.
        do_write(4'h4, 32'hDEADBEEF, 0, 0, 0);
        do_read(4'h4, 0, 0);

        // W arrives three cycles before AW.
        do_write(4'h8, 32'h12345678, 3, 0, 0);
        do_read(4'h8, 0, 0);

        // Held B response, then a back-to-back write.
        do_write(4'h0, 32'hA5A5_0F0F, 0, 0, 5);
        do_write(4'h4, 32'h0000_1111, 0, 1, 0);

        // Out-of-range word index.
        do_write(4'hC, 32'hFFFF_FFFF, 0, 0, 0);
        do_read(4'hC, 1, 2);

        // Read of reg 0 lands on the same edge that commits a new value to reg 0.
        fork
            do_write(4'h0, 32'hCAFE_0001, 0, 0, 0);
            do_read(4'h0, 1, 4);
        join

        for (int i = 0; i < 24; i++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset while both a B and an R response are pending.
        bus.awaddr = 4'h0; bus.wdata = 32'h0BAD_F00D; bus.awvalid = 1; bus.wvalid = 1;
        bus.araddr = 4'h4; bus.arvalid = 1; bus.bready = 0; bus.rready = 0;
        @(posedge aclk); #1;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        @(posedge aclk); #1;
        @(negedge aclk);
        check_eq("pend_bvalid", bus.bvalid, 1);
        check_eq("pend_rvalid", bus.rvalid, 1);
        #2 areset = 1'b1;
        #1;
        check_all_idle_zero("midrst");
        for (int k = 0; k < 4; k++) model_mem[k] = '0;
        @(posedge aclk); #1;
        areset = 1'b0;
        check_eq("rel_ready_low", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge aclk);
        check_eq("rel_ready_low_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge aclk);
        check_eq("rel_ready_high", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(posedge aclk); #1;
        do_read(4'h4, 0, 0);
        do_write(4'h8, 32'h7777_8888, 1, 0, 1);
        do_read(4'h8, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
